// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, op classes, immediate formats
// and the id/ex pipeline bundle.
package rv_pkg;

    localparam int XLEN = 32;
    localparam int RLEN = 5;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        OP_ALU, OP_ALUI, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL,
        OP_JALR, OP_LUI, OP_AUIPC, OP_SYS, OP_FENCE
    } op_e;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_fmt_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        op_e             op;
        logic [2:0]      funct3;
        logic            funct7b5;
        logic [RLEN-1:0] rd;
        logic            wr_rd;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } id_ex_t;

endpackage

// File: rtl/id_stage_if.sv
// Decode stage bus: fetch handshake, regfile read, writeback, flush and id/ex.
// master = surrounding pipeline, slave = id_stage.
interface id_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  if_valid;
    logic                  if_ready;
    logic [31:0]           if_instr;
    logic [DATA_WIDTH-1:0] if_pc;
    logic [REG_ADDR_W-1:0] rf_rs1;
    logic [REG_ADDR_W-1:0] rf_rs2;
    logic [DATA_WIDTH-1:0] rf_rs1_data;
    logic [DATA_WIDTH-1:0] rf_rs2_data;
    logic                  wb_en;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  flush;
    logic                  ex_valid;
    logic                  ex_ready;
    logic [DATA_WIDTH-1:0] ex_pc;
    rv_pkg::op_e           ex_op;
    logic [2:0]            ex_funct3;
    logic                  ex_funct7b5;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_wr_rd;
    logic [DATA_WIDTH-1:0] ex_rs1_val;
    logic [DATA_WIDTH-1:0] ex_rs2_val;
    logic [DATA_WIDTH-1:0] ex_imm;
    logic                  ex_illegal;

    modport master (
        output if_valid, if_instr, if_pc, rf_rs1_data, rf_rs2_data,
        output wb_en, wb_rd, wb_data, flush, ex_ready,
        input  if_ready, rf_rs1, rf_rs2, ex_valid, ex_pc, ex_op,
        input  ex_funct3, ex_funct7b5, ex_rd, ex_wr_rd,
        input  ex_rs1_val, ex_rs2_val, ex_imm, ex_illegal
    );

    modport slave (
        input  if_valid, if_instr, if_pc, rf_rs1_data, rf_rs2_data,
        input  wb_en, wb_rd, wb_data, flush, ex_ready,
        output if_ready, rf_rs1, rf_rs2, ex_valid, ex_pc, ex_op,
        output ex_funct3, ex_funct7b5, ex_rd, ex_wr_rd,
        output ex_rs1_val, ex_rs2_val, ex_imm, ex_illegal
    );
endinterface

// File: rtl/rv_imm_gen.sv
// Combinational RV32I immediate generator.
// Ports: instr (instruction word), fmt (format select) -> imm (sign-extended).
module rv_imm_gen
    import rv_pkg::*;
(
    input  logic [31:0] instr,
    input  imm_fmt_e    fmt,
    output logic [31:0] imm
);
    logic unused_opc;
    assign unused_opc = ^instr[6:0];

    always_comb begin
        imm = '0;
        unique case (fmt)
            IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7],
                          instr[30:25], instr[11:8], 1'b0};
            IMM_U: imm = {instr[31:12], 12'b0};
            IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12],
                          instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end
endmodule

// File: rtl/id_stage.sv
// RV32I decode / operand fetch with writeback bypass and hazard scoreboard.
// Ports: clk, rst_n (async active-low), bus (id_stage_if.slave).
module id_stage
    import rv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    id_stage_if.slave  bus
);
    localparam int NREG = 1 << REG_ADDR_W;

    logic [6:0]            opcode;
    logic [REG_ADDR_W-1:0] rs1, rs2, rd;
    op_e                   op;
    imm_fmt_e              fmt;
    logic                  use_rs1, use_rs2, writes, illegal;
    logic [DATA_WIDTH-1:0] imm, rs1_val, rs2_val;
    logic                  hit1, hit2, hitd, hazard, accept;
    logic [NREG-1:0]       pending, pending_nx;
    id_ex_t                ex_q, ex_d;
    logic                  ex_valid_q;

    assign opcode = bus.if_instr[6:0];
    assign rs1    = bus.if_instr[19:15];
    assign rs2    = bus.if_instr[24:20];
    assign rd     = bus.if_instr[11:7];

    // Every legal opcode ends in 2'b11, so a bad length lands in default.
    always_comb begin
        op      = OP_ALU;
        fmt     = IMM_NONE;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        writes  = 1'b0;
        illegal = 1'b0;
        unique case (1'b1)
            opcode == OPC_LUI: begin
                op = OP_LUI; fmt = IMM_U; writes = 1'b1;
            end
            opcode == OPC_AUIPC: begin
                op = OP_AUIPC; fmt = IMM_U; writes = 1'b1;
            end
            opcode == OPC_JAL: begin
                op = OP_JAL; fmt = IMM_J; writes = 1'b1;
            end
            opcode == OPC_JALR: begin
                op = OP_JALR; fmt = IMM_I;
                writes = 1'b1; use_rs1 = 1'b1;
            end
            opcode == OPC_BRANCH: begin
                op = OP_BRANCH; fmt = IMM_B;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            opcode == OPC_LOAD: begin
                op = OP_LOAD; fmt = IMM_I;
                writes = 1'b1; use_rs1 = 1'b1;
            end
            opcode == OPC_STORE: begin
                op = OP_STORE; fmt = IMM_S;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            opcode == OPC_OPIMM: begin
                op = OP_ALUI; fmt = IMM_I;
                writes = 1'b1; use_rs1 = 1'b1;
            end
            opcode == OPC_OP: begin
                op = OP_ALU; writes = 1'b1;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            opcode == OPC_FENCE: begin
                op = OP_FENCE; fmt = IMM_I;
            end
            opcode == OPC_SYSTEM: begin
                op = OP_SYS; fmt = IMM_I; writes = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    rv_imm_gen u_imm (
        .instr (bus.if_instr),
        .fmt   (fmt),
        .imm   (imm)
    );

    assign hit1 = bus.wb_en && (bus.wb_rd == rs1);
    assign hit2 = bus.wb_en && (bus.wb_rd == rs2);
    assign hitd = bus.wb_en && (bus.wb_rd == rd);

    assign rs1_val = (rs1 == '0) ? '0 : hit1 ? bus.wb_data : bus.rf_rs1_data;
    assign rs2_val = (rs2 == '0) ? '0 : hit2 ? bus.wb_data : bus.rf_rs2_data;

    // A register being written back this cycle is no longer a hazard.
    assign hazard = (use_rs1 && pending[rs1] && !hit1)
                 || (use_rs2 && pending[rs2] && !hit2)
                 || (writes && pending[rd] && !hitd);

    assign bus.if_ready = !bus.flush && !hazard
                       && (!ex_valid_q || bus.ex_ready);
    assign accept = bus.if_valid && bus.if_ready;

    always_comb begin
        ex_d          = '0;
        ex_d.pc       = bus.if_pc;
        ex_d.op       = op;
        ex_d.funct3   = bus.if_instr[14:12];
        ex_d.funct7b5 = bus.if_instr[30];
        ex_d.rd       = rd;
        ex_d.wr_rd    = writes && (rd != '0);
        ex_d.rs1_val  = rs1_val;
        ex_d.rs2_val  = rs2_val;
        ex_d.imm      = imm;
        ex_d.illegal  = illegal;
    end

    // Clears first, then the accept-side set so it overrides a same-index clear.
    always_comb begin
        pending_nx = pending;
        if (bus.wb_en)
            pending_nx[bus.wb_rd] = 1'b0;
        if (bus.flush && ex_valid_q && ex_q.wr_rd)
            pending_nx[ex_q.rd] = 1'b0;
        if (accept && ex_d.wr_rd)
            pending_nx[rd] = 1'b1;
        pending_nx[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= '0;
            ex_q       <= '0;
            ex_valid_q <= 1'b0;
        end else begin
            pending <= pending_nx;
            if (accept) begin
                ex_q       <= ex_d;
                ex_valid_q <= 1'b1;
            end else if (bus.flush || bus.ex_ready) begin
                ex_valid_q <= 1'b0;
            end
        end
    end

    assign bus.rf_rs1      = rs1;
    assign bus.rf_rs2      = rs2;
    assign bus.ex_valid    = ex_valid_q;
    assign bus.ex_pc       = ex_q.pc;
    assign bus.ex_op       = ex_q.op;
    assign bus.ex_funct3   = ex_q.funct3;
    assign bus.ex_funct7b5 = ex_q.funct7b5;
    assign bus.ex_rd       = ex_q.rd;
    assign bus.ex_wr_rd    = ex_q.wr_rd;
    assign bus.ex_rs1_val  = ex_q.rs1_val;
    assign bus.ex_rs2_val  = ex_q.rs2_val;
    assign bus.ex_imm      = ex_q.imm;
    assign bus.ex_illegal  = ex_q.illegal;
endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios plus randomized traffic
// checked against a behavioural decode/scoreboard model.
module tb_id_stage;
    import rv_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_stage_if bus ();

    id_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [31:0] rf [32];
    always_comb begin
        bus.rf_rs1_data = rf[bus.if_instr[19:15]];
        bus.rf_rs2_data = rf[bus.if_instr[24:20]];
    end

    int checks = 0;
    int errors = 0;

    id_ex_t      m_ex;
    logic        m_valid;
    logic [31:0] m_pend;
    logic        last_ready;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_decode(input logic [31:0] i,
                                         input logic [31:0] pc,
                                         output id_ex_t d,
                                         output logic u1, output logic u2,
                                         output logic wr);
        logic [31:0] im_i, im_s, im_b, im_u, im_j;
        im_i = 32'($signed(i[31:20]));
        im_s = 32'($signed({i[31:25], i[11:7]}));
        im_b = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
        im_u = {i[31:12], 12'h000};
        im_j = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
        d = '0;
        u1 = 1'b0; u2 = 1'b0; wr = 1'b0;
        d.pc = pc;
        d.funct3 = i[14:12];
        d.funct7b5 = i[30];
        d.rd = i[11:7];
        d.op = OP_ALU;
        case (i[6:0])
            7'h37: begin d.op = OP_LUI;    d.imm = im_u; wr = 1; end
            7'h17: begin d.op = OP_AUIPC;  d.imm = im_u; wr = 1; end
            7'h6F: begin d.op = OP_JAL;    d.imm = im_j; wr = 1; end
            7'h67: begin d.op = OP_JALR;   d.imm = im_i; wr = 1; u1 = 1; end
            7'h63: begin d.op = OP_BRANCH; d.imm = im_b; u1 = 1; u2 = 1; end
            7'h03: begin d.op = OP_LOAD;   d.imm = im_i; wr = 1; u1 = 1; end
            7'h23: begin d.op = OP_STORE;  d.imm = im_s; u1 = 1; u2 = 1; end
            7'h13: begin d.op = OP_ALUI;   d.imm = im_i; wr = 1; u1 = 1; end
            7'h33: begin d.op = OP_ALU;    wr = 1; u1 = 1; u2 = 1; end
            7'h0F: begin d.op = OP_FENCE;  d.imm = im_i; end
            7'h73: begin d.op = OP_SYS;    d.imm = im_i; wr = 1; end
            default: d.illegal = 1'b1;
        endcase
        d.wr_rd = wr && (d.rd != 5'd0);
    endfunction

    function automatic logic [31:0] opval(input logic [4:0] r);
        if (r == 5'd0) return 32'h0;
        if (bus.wb_en && bus.wb_rd == r) return bus.wb_data;
        return rf[r];
    endfunction

    task automatic check_regs();
        chk("ex_valid", 32'(bus.ex_valid), 32'(m_valid));
        chk("ex_pc", bus.ex_pc, m_ex.pc);
        chk("ex_op", 32'(bus.ex_op), 32'(m_ex.op));
        chk("ex_funct3", 32'(bus.ex_funct3), 32'(m_ex.funct3));
        chk("ex_funct7b5", 32'(bus.ex_funct7b5), 32'(m_ex.funct7b5));
        chk("ex_rd", 32'(bus.ex_rd), 32'(m_ex.rd));
        chk("ex_wr_rd", 32'(bus.ex_wr_rd), 32'(m_ex.wr_rd));
        chk("ex_rs1_val", bus.ex_rs1_val, m_ex.rs1_val);
        chk("ex_rs2_val", bus.ex_rs2_val, m_ex.rs2_val);
        chk("ex_imm", bus.ex_imm, m_ex.imm);
        chk("ex_illegal", 32'(bus.ex_illegal), 32'(m_ex.illegal));
        chk("pending", dut.pending, m_pend);
    endtask

    task automatic drive(input logic v, input logic [31:0] ins,
                         input logic [31:0] pc, input logic we,
                         input logic [4:0] wrd, input logic [31:0] wd,
                         input logic fl, input logic er);
        bus.if_valid = v;
        bus.if_instr = ins;
        bus.if_pc = pc;
        bus.wb_en = we;
        bus.wb_rd = wrd;
        bus.wb_data = wd;
        bus.flush = fl;
        bus.ex_ready = er;
    endtask

    // One clock: check combinational outputs, step the model, check state.
    task automatic cycle_check();
        id_ex_t d;
        logic u1, u2, wr, haz, exp_ready, acc;
        logic [4:0] r1, r2, rd;
        logic [31:0] np;
        #1;
        model_decode(bus.if_instr, bus.if_pc, d, u1, u2, wr);
        r1 = bus.if_instr[19:15];
        r2 = bus.if_instr[24:20];
        rd = bus.if_instr[11:7];
        d.rs1_val = opval(r1);
        d.rs2_val = opval(r2);
        haz = (u1 && m_pend[r1] && !(bus.wb_en && bus.wb_rd == r1))
           || (u2 && m_pend[r2] && !(bus.wb_en && bus.wb_rd == r2))
           || (wr && m_pend[rd] && !(bus.wb_en && bus.wb_rd == rd));
        exp_ready = !bus.flush && !haz && (!m_valid || bus.ex_ready);
        last_ready = bus.if_ready;
        chk("if_ready", 32'(bus.if_ready), 32'(exp_ready));
        chk("rf_rs1", 32'(bus.rf_rs1), 32'(r1));
        chk("rf_rs2", 32'(bus.rf_rs2), 32'(r2));
        acc = bus.if_valid && exp_ready;
        np = m_pend;
        if (bus.wb_en) np[bus.wb_rd] = 1'b0;
        if (bus.flush && m_valid && m_ex.wr_rd) np[m_ex.rd] = 1'b0;
        if (acc && d.wr_rd) np[rd] = 1'b1;
        np[0] = 1'b0;
        if (acc) begin
            m_ex = d;
            m_valid = 1'b1;
        end else if (bus.flush || (m_valid && bus.ex_ready)) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        m_pend = np;
        check_regs();
    endtask

    task automatic do_reset();
        drive(0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 0, 1);
        rst_n = 1'b0;
        #1;
        m_ex = '0;
        m_valid = 1'b0;
        m_pend = '0;
        check_regs();
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] i;
        i = $urandom;
        i[19:15] = 5'($urandom_range(0, 7));
        i[24:20] = 5'($urandom_range(0, 7));
        i[11:7] = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 12))
            0: i[6:0] = 7'h37;
            1: i[6:0] = 7'h17;
            2: i[6:0] = 7'h6F;
            3: i[6:0] = 7'h67;
            4: i[6:0] = 7'h63;
            5: i[6:0] = 7'h03;
            6: i[6:0] = 7'h23;
            7: i[6:0] = 7'h13;
            8: i[6:0] = 7'h33;
            9: i[6:0] = 7'h0F;
            10: i[6:0] = 7'h73;
            11: i[6:0] = 7'h33;
            default: ;
        endcase
        return i;
    endfunction

    initial begin
        logic [4:0] wrd;
        int start;
        for (int k = 0; k < 32; k++) rf[k] = $urandom;
        rf[0] = 32'hDEADBEEF;
        m_ex = '0;
        m_valid = 1'b0;
        m_pend = '0;
        last_ready = 1'b0;
        drive(0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 0, 1);
        @(posedge clk);
        #1;
        check_regs();
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ADDI x5,x0,7 then dependent ADD x6,x5,x5
        drive(1, 32'h00700293, 32'h10, 0, 5'd0, 32'h0, 0, 1);
        cycle_check();
        chk("addi_pend5", 32'(dut.pending[5]), 32'h1);
        drive(1, 32'h00528333, 32'h14, 0, 5'd0, 32'h0, 0, 1);
        cycle_check();
        chk("raw_stall", 32'(last_ready), 32'h0);
        drive(1, 32'h00528333, 32'h14, 1, 5'd5, 32'h7, 0, 1);
        cycle_check();
        chk("bypass_ready", 32'(last_ready), 32'h1);
        chk("bypass_rs1", bus.ex_rs1_val, 32'h7);
        chk("bypass_rs2", bus.ex_rs2_val, 32'h7);
        chk("pend_after_wb", dut.pending, 32'h40);

        // x0 destination and x0 sources
        drive(1, 32'h00108013, 32'h18, 0, 5'd0, 32'h0, 0, 1);
        cycle_check();
        chk("x0_wr_rd", 32'(bus.ex_wr_rd), 32'h0);
        chk("x0_pend", dut.pending, 32'h40);
        drive(1, 32'h00000133, 32'h1C, 0, 5'd0, 32'h0, 0, 1);
        cycle_check();
        chk("x0_ready", 32'(last_ready), 32'h1);
        chk("x0_rs1", bus.ex_rs1_val, 32'h0);
        chk("x0_rs2", bus.ex_rs2_val, 32'h0);

        // immediates
        drive(1, 32'hFE000EE3, 32'h20, 0, 5'd0, 32'h0, 0, 1);
        cycle_check();
        chk("beq_imm", bus.ex_imm, 32'hFFFFFFFC);
        drive(1, 32'h0010006F, 32'h24, 0, 5'd0, 32'h0, 0, 1);
        cycle_check();
        chk("jal_imm", bus.ex_imm, 32'h00000800);

        // LW x7 then flush with ex_ready high
        drive(1, 32'h0000A383, 32'h28, 0, 5'd0, 32'h0, 0, 1);
        cycle_check();
        chk("lw_pend7", 32'(dut.pending[7]), 32'h1);
        drive(1, 32'h00100413, 32'h2C, 0, 5'd0, 32'h0, 1, 1);
        cycle_check();
        chk("flush_ready", 32'(last_ready), 32'h0);
        chk("flush_valid", 32'(bus.ex_valid), 32'h0);
        chk("flush_pend7", 32'(dut.pending[7]), 32'h0);
        drive(1, 32'h00100413, 32'h2C, 0, 5'd0, 32'h0, 0, 1);
        cycle_check();
        chk("post_flush_acc", 32'(last_ready), 32'h1);
        chk("post_flush_rd", 32'(bus.ex_rd), 32'h8);

        // illegal opcode, then execute back-pressure
        drive(1, 32'h0000007F, 32'h100, 0, 5'd0, 32'h0, 0, 1);
        cycle_check();
        chk("ill_ready", 32'(last_ready), 32'h1);
        chk("ill_flag", 32'(bus.ex_illegal), 32'h1);
        chk("ill_wr_rd", 32'(bus.ex_wr_rd), 32'h0);
        for (int c = 0; c < 3; c++) begin
            drive(1, 32'h00100493, 32'h104, 0, 5'd0, 32'h0, 0, 0);
            cycle_check();
            chk("hold_ready", 32'(last_ready), 32'h0);
            chk("hold_valid", 32'(bus.ex_valid), 32'h1);
            chk("hold_pc", bus.ex_pc, 32'h100);
            chk("hold_ill", 32'(bus.ex_illegal), 32'h1);
        end

        // reset with a valid entry and pending[5]
        drive(1, 32'h00700293, 32'h108, 0, 5'd0, 32'h0, 0, 1);
        cycle_check();
        chk("pre_rst_pend5", 32'(dut.pending[5]), 32'h1);
        do_reset();
        chk("rst_valid", 32'(bus.ex_valid), 32'h0);
        chk("rst_pend", dut.pending, 32'h0);
        drive(0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 0, 1);
        cycle_check();
        chk("rst_ready", 32'(last_ready), 32'h1);

        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
                continue;
            end
            wrd = 5'($urandom_range(0, 7));
            if (m_pend != 0 && $urandom_range(0, 3) != 0) begin
                start = $urandom_range(0, 31);
                for (int k = 0; k < 32; k++) begin
                    if (m_pend[(start + k) % 32]) begin
                        wrd = 5'((start + k) % 32);
                        break;
                    end
                end
            end
            drive($urandom_range(0, 9) < 8, rand_instr(), $urandom,
                  $urandom_range(0, 9) < 4, wrd, $urandom,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
            cycle_check();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Single-issue, in-order RV32I decode / operand-fetch stage between fetch and execute.
- Decodes the instruction, drives register read addresses to the 32-entry integer register file and captures operands, with bypass from writeback.
- Tracks in-flight destination registers in a scoreboard and stalls fetch on RAW/WAW hazards.
- Holds results in a one-entry id/ex pipeline register under a valid/ready handshake.

Parameters:
DATA_WIDTH, 32, operand/PC width
REG_ADDR_W, 5, register index width (32 registers)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
if_valid  in  1  fetch presents instruction
if_ready  out  1  decode accepts instruction this cycle
if_instr  in  32  instruction word
if_pc  in  DATA_WIDTH  instruction PC
rf_rs1  out  REG_ADDR_W  register file read address 1 (= if_instr[19:15])
rf_rs2  out  REG_ADDR_W  register file read address 2 (= if_instr[24:20])
rf_rs1_data  in  DATA_WIDTH  combinational read data 1
rf_rs2_data  in  DATA_WIDTH  combinational read data 2
wb_en  in  1  writeback commits this cycle
wb_rd  in  REG_ADDR_W  writeback destination
wb_data  in  DATA_WIDTH  writeback value
flush  in  1  kill id/ex entry and fetch input (taken branch/jump)
ex_valid  out  1  id/ex entry valid
ex_ready  in  1  execute consumes entry
ex_pc  out  DATA_WIDTH  PC
ex_op  out  4  op class (rv_pkg::op_e)
ex_funct3  out  3  funct3
ex_funct7b5  out  1  instr[30]
ex_rd  out  REG_ADDR_W  destination
ex_wr_rd  out  1  writes rd (rd != 0 and op writes)
ex_rs1_val  out  DATA_WIDTH  operand 1
ex_rs2_val  out  DATA_WIDTH  operand 2
ex_imm  out  DATA_WIDTH  sign-extended immediate
ex_illegal  out  1  illegal instruction flag

Behaviour:
- Reset (async, rst_n low): ex_valid=0; all ex_* outputs 0; scoreboard pending[31:0]=0. Operation resumes on the first clk edge after deassertion.
- Decode:
  - Opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, FENCE, SYSTEM.
  - Any other opcode, or instr[1:0]!=2'b11: ex_illegal=1, ex_wr_rd=0, no hazard checks.
- Immediates: I/S/B/U/J formats, sign-extended from instr[31]. R-type ex_imm=0.
- Source use:
  - use_rs1 for JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - use_rs2 for BRANCH, STORE, OP.
  - Index 0 never hazards; its value is 0.
- Bypass: operand value = wb_data when wb_en and wb_rd==src!=0, else rf data. x0 always yields 0.
- Hazard (combinational), any of:
  - use_rsN and pending[rsN] and not (wb_en and wb_rd==rsN).
  - writes_rd and pending[rd] and not (wb_en and wb_rd==rd) (WAW).
- Ready: if_ready = !flush and !hazard and (!ex_valid or ex_ready).
- Accept: accept = if_valid and if_ready. On accept, the id/ex register loads on the next edge (1-cycle latency) and ex_valid=1.
- Drain: if ex_valid and ex_ready and no accept, ex_valid<=0.
- Scoreboard:
  - Set on accept: pending[rd]<=1 if ex_wr_rd for the accepted instruction.
  - Clear: on wb_en, pending[wb_rd]<=0.
  - Same index set and cleared in the same cycle: set wins.
  - pending[0] is always 0.
- Flush:
  - ex_valid<=0 even if ex_ready is high (flush wins).
  - Incoming instruction is not accepted.
  - If ex_valid and ex_wr_rd, clear pending[ex_rd]; a coincident wb_en clear is also applied.
- Stall stability: while ex_valid and !ex_ready, all ex_* outputs hold.

Decomposition:
- rv_pkg holds:
  - opcode localparams
  - op_e enum (ALU, ALUI, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYS, FENCE)
  - imm_fmt_e enum
  - id_ex_t struct
- Sub-module rv_imm_gen: combinational (instr, imm_fmt) -> imm.
- The scoreboard stays inline.

Test Plan:
- Reset mid-stream with ex_valid=1, pending[5]=1 -> next cycle ex_valid=0, pending=0, if_ready=1.
- ADDI x5,x0,7 then ADD x6,x5,x5 back-to-back, no wb -> second stalls (if_ready=0); wb_en, wb_rd=5, wb_data=7 -> accepted that cycle, ex_rs1_val=ex_rs2_val=7, pending[5]=0, pending[6]=1.
- ADDI x0,x1,1 -> ex_wr_rd=0, pending unchanged; following ADD x2,x0,x0 never stalls, operands 0.
- BEQ with imm -4 (0xFE000EE3) -> ex_imm=0xFFFFFFFC; JAL imm +2048 -> ex_imm=0x00000800.
- LW x7 accepted, then flush while ex_ready=1 -> ex_valid=0, pending[7]=0; if_valid held, accepted next cycle.
- Opcode 0x7F -> ex_illegal=1, ex_wr_rd=0, no stall; ex_ready=0 for 3 cycles -> ex_* outputs stable, if_ready=0.
